// File: rtl/uart_frame_decoder.sv
// Length-framed packet decoder behind a UART receiver: SYNC, LEN, PAYLOAD[LEN], CHK.
// Good frames are buffered and replayed over a valid/ready byte stream; bad frames are flagged.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 104_166
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        new_data_in,
  input  logic [7:0]  data_byte_in,
  output logic        payload_valid_out,
  output logic [7:0]  payload_byte_out,
  output logic        payload_last_out,
  input  logic        payload_ready_in,
  output logic        frame_error_out,
  output logic [1:0]  error_code_out,
  output logic        overrun_out,
  output logic [15:0] frame_count_out
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] len;
  logic [7:0]       acc;
  logic [31:0]      idle;
  logic [7:0]       buffer [MAX_LEN];

  logic [7:0]       sum;
  logic             len_bad;
  logic             timed_out;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] next_idx;

  assign sum       = acc + data_byte_in;
  assign len_bad   = (data_byte_in == 8'd0) || (data_byte_in > 8'(MAX_LEN));
  // A strobe on the limit cycle takes priority over the timeout.
  assign timed_out = !new_data_in && (idle == 32'(TIMEOUT_CYCLES - 1));
  assign last_idx  = len - IDX_W'(1);
  assign next_idx  = index + IDX_W'(1);

  always_ff @(posedge clk_in) begin
    if (state == PAYLOAD && new_data_in)
      buffer[index[ADDR_W-1:0]] <= data_byte_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= HUNT;
      index             <= '0;
      len               <= '0;
      acc               <= '0;
      idle              <= '0;
      payload_valid_out <= 1'b0;
      payload_byte_out  <= '0;
      payload_last_out  <= 1'b0;
      frame_error_out   <= 1'b0;
      error_code_out    <= '0;
      overrun_out       <= 1'b0;
      frame_count_out   <= '0;
    end else begin
      frame_error_out <= 1'b0;
      overrun_out     <= 1'b0;
      case (state)
        HUNT: begin
          idle <= '0;
          if (new_data_in && data_byte_in == SYNC_BYTE)
            state <= LEN;
        end
        LEN: begin
          if (new_data_in) begin
            idle <= '0;
            if (len_bad) begin
              state           <= HUNT;
              frame_error_out <= 1'b1;
              error_code_out  <= 2'd1;
            end else begin
              len   <= data_byte_in[IDX_W-1:0];
              acc   <= data_byte_in;
              index <= '0;
              state <= PAYLOAD;
            end
          end else if (timed_out) begin
            idle            <= '0;
            state           <= HUNT;
            frame_error_out <= 1'b1;
            error_code_out  <= 2'd3;
          end else begin
            idle <= idle + 32'd1;
          end
        end
        PAYLOAD: begin
          if (new_data_in) begin
            idle  <= '0;
            acc   <= sum;
            index <= next_idx;
            if (index == last_idx)
              state <= CHECK;
          end else if (timed_out) begin
            idle            <= '0;
            state           <= HUNT;
            frame_error_out <= 1'b1;
            error_code_out  <= 2'd3;
          end else begin
            idle <= idle + 32'd1;
          end
        end
        CHECK: begin
          if (new_data_in) begin
            idle <= '0;
            if (sum == 8'd0) begin
              frame_count_out   <= frame_count_out + 16'd1;
              index             <= '0;
              state             <= DRAIN;
              payload_valid_out <= 1'b1;
              payload_byte_out  <= buffer[0];
              payload_last_out  <= (len == IDX_W'(1));
            end else begin
              state           <= HUNT;
              frame_error_out <= 1'b1;
              error_code_out  <= 2'd2;
            end
          end else if (timed_out) begin
            idle            <= '0;
            state           <= HUNT;
            frame_error_out <= 1'b1;
            error_code_out  <= 2'd3;
          end else begin
            idle <= idle + 32'd1;
          end
        end
        DRAIN: begin
          idle <= '0;
          // The parser is busy replaying, so incoming bytes cannot be kept.
          if (new_data_in)
            overrun_out <= 1'b1;
          if (payload_valid_out && payload_ready_in) begin
            if (payload_last_out) begin
              payload_valid_out <= 1'b0;
              payload_last_out  <= 1'b0;
              payload_byte_out  <= '0;
              state             <= HUNT;
            end else begin
              index            <= next_idx;
              payload_byte_out <= buffer[next_idx[ADDR_W-1:0]];
              payload_last_out <= (next_idx == last_idx);
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder with payload and error scoreboards.
module tb_uart_frame_decoder;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        new_data_in = 1'b0;
  logic [7:0]  data_byte_in = 8'h00;
  logic        payload_ready_in = 1'b1;
  logic        payload_valid_out;
  logic [7:0]  payload_byte_out;
  logic        payload_last_out;
  logic        frame_error_out;
  logic [1:0]  error_code_out;
  logic        overrun_out;
  logic [15:0] frame_count_out;

  int compared = 0;
  int mismatched = 0;
  int overrun_seen = 0;
  int overrun_base = 0;
  int exp_frames = 0;

  logic [8:0] exp_q [$];
  logic [1:0] err_q [$];
  logic [7:0] frame_bytes [$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_last = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_byte = 8'h00;

  uart_frame_decoder #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN(16),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .new_data_in(new_data_in),
    .data_byte_in(data_byte_in),
    .payload_valid_out(payload_valid_out),
    .payload_byte_out(payload_byte_out),
    .payload_last_out(payload_last_out),
    .payload_ready_in(payload_ready_in),
    .frame_error_out(frame_error_out),
    .error_code_out(error_code_out),
    .overrun_out(overrun_out),
    .frame_count_out(frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobed byte; called and returns at 1 time unit after a rising edge.
  task automatic apply_stimulus(input logic [7:0] b);
    new_data_in  = 1'b1;
    data_byte_in = b;
    @(posedge clk_in); #1;
    new_data_in  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic send_frame(input bit corrupt);
    logic [7:0] sum;
    logic [7:0] chk;
    sum = 8'(frame_bytes.size());
    apply_stimulus(SYNC);
    apply_stimulus(8'(frame_bytes.size()));
    for (int i = 0; i < frame_bytes.size(); i++) begin
      sum = sum + frame_bytes[i];
      if (!corrupt)
        exp_q.push_back({(i == frame_bytes.size() - 1), frame_bytes[i]});
      apply_stimulus(frame_bytes[i]);
    end
    chk = 8'h00 - sum;
    if (corrupt) begin
      chk = chk + 8'h01;
      err_q.push_back(2'd2);
    end else begin
      exp_frames++;
    end
    apply_stimulus(chk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && payload_valid_out !== 1'b1)
        break;
      @(posedge clk_in); #1;
    end
    check_output("drain_done", 32'(exp_q.size()), 32'd0);
    check_output("drain_valid_low", 32'(payload_valid_out), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_valid"}, 32'(payload_valid_out), 32'd0);
    check_output({tag, "_byte"}, 32'(payload_byte_out), 32'd0);
    check_output({tag, "_last"}, 32'(payload_last_out), 32'd0);
    check_output({tag, "_err"}, 32'(frame_error_out), 32'd0);
    check_output({tag, "_code"}, 32'(error_code_out), 32'd0);
    check_output({tag, "_ovr"}, 32'(overrun_out), 32'd0);
    check_output({tag, "_count"}, 32'(frame_count_out), 32'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk_in) begin
    logic [8:0] e;
    logic [1:0] c;
    if (!rst_in) begin
      if (prev_valid === 1'b1 && prev_ready === 1'b0 && !prev_rst) begin
        check_output("hold_valid", 32'(payload_valid_out), 32'd1);
        check_output("hold_byte", 32'(payload_byte_out), 32'(prev_byte));
        check_output("hold_last", 32'(payload_last_out), 32'(prev_last));
      end
      if (payload_valid_out === 1'b1 && payload_ready_in) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $error("[TB] FAIL unexpected_byte: observed %0h expected none", payload_byte_out);
        end else begin
          e = exp_q.pop_front();
          check_output("payload_byte", 32'(payload_byte_out), 32'(e[7:0]));
          check_output("payload_last", 32'(payload_last_out), 32'(e[8]));
        end
      end
      if (frame_error_out === 1'b1) begin
        if (err_q.size() == 0) begin
          compared++;
          mismatched++;
          $error("[TB] FAIL unexpected_error: observed code %0d expected none", error_code_out);
        end else begin
          c = err_q.pop_front();
          check_output("error_code", 32'(error_code_out), 32'(c));
        end
      end
      if (overrun_out === 1'b1)
        overrun_seen++;
    end
    prev_valid = payload_valid_out;
    prev_ready = payload_ready_in;
    prev_last  = payload_last_out;
    prev_byte  = payload_byte_out;
    prev_rst   = rst_in;
  end

  initial begin
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    rst_in = 1'b0;
    idle_cycles(1);

    // Good frame with fixed constants, checking latency and back-to-back delivery.
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    exp_frames++;
    apply_stimulus(8'hA5);
    apply_stimulus(8'h03);
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    check_output("valid_before_chk", 32'(payload_valid_out), 32'd0);
    apply_stimulus(8'h97);
    check_output("good_valid0", 32'(payload_valid_out), 32'd1);
    check_output("good_byte0", 32'(payload_byte_out), 32'h11);
    check_output("good_last0", 32'(payload_last_out), 32'd0);
    check_output("good_count", 32'(frame_count_out), 32'd1);
    idle_cycles(1);
    check_output("good_byte1", 32'(payload_byte_out), 32'h22);
    idle_cycles(1);
    check_output("good_byte2", 32'(payload_byte_out), 32'h33);
    check_output("good_last2", 32'(payload_last_out), 32'd1);
    idle_cycles(1);
    check_output("good_valid_end", 32'(payload_valid_out), 32'd0);
    idle_cycles(2);

    // Bad checksum, then a good frame containing a SYNC value as data.
    frame_bytes = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b1);
    check_output("badchk_pulse", 32'(frame_error_out), 32'd1);
    check_output("badchk_code", 32'(error_code_out), 32'd2);
    idle_cycles(3);
    check_output("badchk_novalid", 32'(payload_valid_out), 32'd0);
    frame_bytes = '{8'hA5, 8'h5A, 8'h00};
    send_frame(1'b0);
    wait_drain();
    check_output("after_badchk_count", 32'(frame_count_out), 32'(exp_frames));

    // Leading garbage, then zero, oversize and just-oversize lengths.
    apply_stimulus(8'h00);
    apply_stimulus(8'hFF);
    check_output("garbage_noerr", 32'(frame_error_out), 32'd0);
    err_q.push_back(2'd1);
    apply_stimulus(SYNC);
    apply_stimulus(8'h00);
    check_output("len0_pulse", 32'(frame_error_out), 32'd1);
    check_output("len0_code", 32'(error_code_out), 32'd1);
    idle_cycles(2);
    err_q.push_back(2'd1);
    apply_stimulus(SYNC);
    apply_stimulus(8'h20);
    check_output("len32_pulse", 32'(frame_error_out), 32'd1);
    err_q.push_back(2'd1);
    apply_stimulus(SYNC);
    apply_stimulus(8'h11);
    check_output("len17_pulse", 32'(frame_error_out), 32'd1);
    idle_cycles(1);
    frame_bytes.delete();
    for (int i = 1; i <= 16; i++)
      frame_bytes.push_back(8'(i));
    send_frame(1'b0);
    wait_drain();
    check_output("maxlen_count", 32'(frame_count_out), 32'(exp_frames));

    // Timeout exactly 50 idle cycles after the last strobe.
    err_q.push_back(2'd3);
    apply_stimulus(SYNC);
    apply_stimulus(8'h02);
    apply_stimulus(8'h44);
    idle_cycles(49);
    check_output("no_early_timeout", 32'(frame_error_out), 32'd0);
    idle_cycles(1);
    check_output("timeout_pulse", 32'(frame_error_out), 32'd1);
    check_output("timeout_code", 32'(error_code_out), 32'd3);
    idle_cycles(2);

    // A strobe on the limit cycle is accepted.
    apply_stimulus(SYNC);
    apply_stimulus(8'h02);
    apply_stimulus(8'h44);
    idle_cycles(49);
    exp_q.push_back({1'b0, 8'h44});
    exp_q.push_back({1'b1, 8'h55});
    apply_stimulus(8'h55);
    check_output("limit_strobe_noerr", 32'(frame_error_out), 32'd0);
    exp_frames++;
    apply_stimulus(8'h65);
    wait_drain();
    check_output("limit_count", 32'(frame_count_out), 32'(exp_frames));

    // Backpressure with an overrun strobe injected mid-drain.
    frame_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    payload_ready_in = 1'b0;
    send_frame(1'b0);
    overrun_base = overrun_seen;
    for (int i = 0; i < 60; i++) begin
      payload_ready_in = (i % 3 == 0);
      new_data_in  = (i == 4);
      data_byte_in = SYNC;
      @(posedge clk_in); #1;
      new_data_in = 1'b0;
      if (exp_q.size() == 0 && payload_valid_out !== 1'b1)
        break;
    end
    payload_ready_in = 1'b1;
    idle_cycles(1);
    check_output("bp_all_delivered", 32'(exp_q.size()), 32'd0);
    check_output("bp_overrun_count", 32'(overrun_seen - overrun_base), 32'd1);
    check_output("bp_frame_count", 32'(frame_count_out), 32'(exp_frames));

    // Reset while draining.
    frame_bytes = '{8'h10, 8'h20, 8'h30};
    payload_ready_in = 1'b0;
    send_frame(1'b0);
    check_output("pre_reset_valid", 32'(payload_valid_out), 32'd1);
    rst_in = 1'b1;
    exp_q.delete();
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    exp_frames = 0;
    check_reset_outputs("midreset");
    payload_ready_in = 1'b1;
    frame_bytes = '{8'h77};
    send_frame(1'b0);
    wait_drain();
    check_output("post_reset_count", 32'(frame_count_out), 32'd1);

    idle_cycles(2);
    check_output("err_q_empty", 32'(err_q.size()), 32'd0);
    check_output("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
